// File: rtl/instruction_fetch_if.sv
// Bundle of the PC, instruction-memory and decode-side handshakes of the fetch stage.
// master is the fetch unit's view; slave is the surrounding pipeline/memory view.
interface instruction_fetch_if;
  logic [31:0] pc_in;
  logic        pc_valid;
  logic        pc_ready;
  logic        flush;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_gnt;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;
  logic        inst_valid;
  logic        inst_ready;
  logic [31:0] inst_out;
  logic [31:0] inst_pc;
  logic        inst_fault;

  modport master (
    input  pc_in, pc_valid, flush, imem_gnt, imem_rvalid, imem_rdata, inst_ready,
    output pc_ready, imem_req, imem_addr, inst_valid, inst_out, inst_pc, inst_fault
  );

  modport slave (
    output pc_in, pc_valid, flush, imem_gnt, imem_rvalid, imem_rdata, inst_ready,
    input  pc_ready, imem_req, imem_addr, inst_valid, inst_out, inst_pc, inst_fault
  );
endinterface

// File: rtl/instruction_fetch.sv
// Fetch stage: turns accepted PCs into req/gnt memory reads and queues {word, pc, fault}
// in a small registered FIFO for decode; misaligned PCs become NOP fault entries.
module instruction_fetch #(
  parameter int          DEPTH = 2,
  parameter logic [31:0] NOP   = 32'h00000013
) (
  input logic               clk,
  input logic               rst_n,
  instruction_fetch_if.master bus
);
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    WAIT = 2'd2
  } state_t;

  state_t      state_r, state_s;
  logic [31:0] addr_r, addr_s;
  logic        kill_r, kill_s;

  logic [31:0] word_mem_r  [DEPTH];
  logic [31:0] pc_mem_r    [DEPTH];
  logic        fault_mem_r [DEPTH];
  logic [PW-1:0] wptr_r, rptr_r;
  logic [CW-1:0] count_r;

  logic        pc_ready_s, accept_s, aligned_s;
  logic        push_s, pop_s;
  logic [31:0] push_word_s, push_pc_s;
  logic        push_fault_s;

  // Accept qualification; held low during reset and while a flush is pending
  always_comb begin
    pc_ready_s = rst_n && (state_r == IDLE) && (count_r < DEPTH_C) && !bus.flush;
    accept_s   = bus.pc_valid && pc_ready_s;
    aligned_s  = (bus.pc_in[1:0] == 2'b00);
  end

  // FSM state, latched request address and kill flag
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= IDLE;
      addr_r  <= 32'h0000_0000;
      kill_r  <= 1'b0;
    end else begin
      state_r <= state_s;
      addr_r  <= addr_s;
      kill_r  <= kill_s;
    end
  end

  // Next-state logic; a flush never withdraws a request, it only marks the response dead
  always_comb begin
    state_s = state_r;
    addr_s  = addr_r;
    kill_s  = kill_r;
    case (state_r)
      IDLE: begin
        kill_s = 1'b0;
        if (accept_s && aligned_s) begin
          state_s = REQ;
          addr_s  = bus.pc_in;
        end else begin
          state_s = IDLE;
        end
      end
      REQ: begin
        if (bus.flush) begin
          kill_s = 1'b1;
        end else begin
          kill_s = kill_r;
        end
        if (bus.imem_gnt) begin
          state_s = WAIT;
        end else begin
          state_s = REQ;
        end
      end
      WAIT: begin
        if (bus.flush) begin
          kill_s = 1'b1;
        end else begin
          kill_s = kill_r;
        end
        if (bus.imem_rvalid) begin
          state_s = IDLE;
          kill_s  = 1'b0;
        end else begin
          state_s = WAIT;
        end
      end
      default: begin
        state_s = IDLE;
        kill_s  = 1'b0;
      end
    endcase
  end

  // FIFO push source select: misaligned fault entry or live memory response
  always_comb begin
    push_s       = 1'b0;
    push_word_s  = NOP;
    push_pc_s    = 32'h0000_0000;
    push_fault_s = 1'b0;
    if (accept_s && !aligned_s) begin
      push_s       = 1'b1;
      push_word_s  = NOP;
      push_pc_s    = bus.pc_in;
      push_fault_s = 1'b1;
    end else if ((state_r == WAIT) && bus.imem_rvalid && !kill_r) begin
      push_s       = 1'b1;
      push_word_s  = bus.imem_rdata;
      push_pc_s    = addr_r;
      push_fault_s = 1'b0;
    end else begin
      push_s = 1'b0;
    end
    pop_s = (count_r != {CW{1'b0}}) && bus.inst_ready;
  end

  // FIFO storage and pointers; flush empties the queue and drops a same-cycle push
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        word_mem_r[i]  <= NOP;
        pc_mem_r[i]    <= 32'h0000_0000;
        fault_mem_r[i] <= 1'b0;
      end
      wptr_r  <= {PW{1'b0}};
      rptr_r  <= {PW{1'b0}};
      count_r <= {CW{1'b0}};
    end else if (bus.flush) begin
      wptr_r  <= {PW{1'b0}};
      rptr_r  <= {PW{1'b0}};
      count_r <= {CW{1'b0}};
    end else begin
      if (push_s) begin
        word_mem_r[wptr_r]  <= push_word_s;
        pc_mem_r[wptr_r]    <= push_pc_s;
        fault_mem_r[wptr_r] <= push_fault_s;
        wptr_r              <= wptr_r + {{(PW-1){1'b0}}, 1'b1};
      end else begin
        wptr_r <= wptr_r;
      end
      if (pop_s) begin
        rptr_r <= rptr_r + {{(PW-1){1'b0}}, 1'b1};
      end else begin
        rptr_r <= rptr_r;
      end
      if (push_s && !pop_s) begin
        count_r <= count_r + {{(CW-1){1'b0}}, 1'b1};
      end else if (pop_s && !push_s) begin
        count_r <= count_r - {{(CW-1){1'b0}}, 1'b1};
      end else begin
        count_r <= count_r;
      end
    end
  end

  assign bus.pc_ready   = pc_ready_s;
  assign bus.imem_req   = (state_r == REQ);
  assign bus.imem_addr  = addr_r;
  assign bus.inst_valid = (count_r != {CW{1'b0}});
  assign bus.inst_out   = word_mem_r[rptr_r];
  assign bus.inst_pc    = pc_mem_r[rptr_r];
  assign bus.inst_fault = fault_mem_r[rptr_r];
endmodule

// File: tb/tb_instruction_fetch.sv
// Directed bench for instruction_fetch: table of single fetches plus hand sequences
// for FIFO-full back-pressure, flush in WAIT, delayed grant and mid-request reset.
module tb_instruction_fetch;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  instruction_fetch_if bus_if ();

  instruction_fetch #(.DEPTH(2), .NOP(32'h00000013)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus_if)
  );

  int checks = 0;
  int failures = 0;
  localparam logic [31:0] NOP_W = 32'h00000013;

  typedef struct {
    logic [31:0] pc;
    int          gnt_delay;
    logic [31:0] rdata;
    logic [31:0] exp_word;
    logic [31:0] exp_pc;
    logic        exp_fault;
  } vec_t;

  vec_t vecs[5];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Presents pc for one accept and, if aligned, plays the memory side
  task automatic issue(input logic [31:0] pc, input int gnt_delay, input logic [31:0] rdata);
    bus_if.pc_in    = pc;
    bus_if.pc_valid = 1'b1;
    #1;
    chk("pc_ready_at_accept", {31'd0, bus_if.pc_ready}, 32'd1);
    step();
    bus_if.pc_valid = 1'b0;
    if (pc[1:0] == 2'b00) begin
      for (int i = 0; i < gnt_delay; i++) begin
        chk("req_hold", {31'd0, bus_if.imem_req}, 32'd1);
        chk("addr_hold", bus_if.imem_addr, pc);
        step();
      end
      chk("req_at_gnt", {31'd0, bus_if.imem_req}, 32'd1);
      chk("addr_at_gnt", bus_if.imem_addr, pc);
      bus_if.imem_gnt = 1'b1;
      step();
      bus_if.imem_gnt = 1'b0;
      chk("req_after_gnt", {31'd0, bus_if.imem_req}, 32'd0);
      bus_if.imem_rvalid = 1'b1;
      bus_if.imem_rdata  = rdata;
      step();
      bus_if.imem_rvalid = 1'b0;
    end else begin
      chk("no_req_misaligned", {31'd0, bus_if.imem_req}, 32'd0);
    end
  endtask

  task automatic chk_head(input string name, input logic [31:0] w, input logic [31:0] p, input logic f);
    chk({name, "_valid"}, {31'd0, bus_if.inst_valid}, 32'd1);
    chk({name, "_out"}, bus_if.inst_out, w);
    chk({name, "_pc"}, bus_if.inst_pc, p);
    chk({name, "_fault"}, {31'd0, bus_if.inst_fault}, {31'd0, f});
  endtask

  task automatic pop_one();
    bus_if.inst_ready = 1'b1;
    step();
    bus_if.inst_ready = 1'b0;
  endtask

  initial begin
    vecs[0] = '{pc: 32'h00000100, gnt_delay: 0, rdata: 32'h00500093,
                exp_word: 32'h00500093, exp_pc: 32'h00000100, exp_fault: 1'b0};
    vecs[1] = '{pc: 32'h00000102, gnt_delay: 0, rdata: 32'h0,
                exp_word: 32'h00000013, exp_pc: 32'h00000102, exp_fault: 1'b1};
    vecs[2] = '{pc: 32'h0000000C, gnt_delay: 3, rdata: 32'h00C00113,
                exp_word: 32'h00C00113, exp_pc: 32'h0000000C, exp_fault: 1'b0};
    vecs[3] = '{pc: 32'h00000201, gnt_delay: 0, rdata: 32'h0,
                exp_word: 32'h00000013, exp_pc: 32'h00000201, exp_fault: 1'b1};
    vecs[4] = '{pc: 32'hFFFFFFFC, gnt_delay: 1, rdata: 32'h12345678,
                exp_word: 32'h12345678, exp_pc: 32'hFFFFFFFC, exp_fault: 1'b0};

    bus_if.pc_in = 32'h0; bus_if.pc_valid = 1'b0; bus_if.flush = 1'b0;
    bus_if.imem_gnt = 1'b0; bus_if.imem_rvalid = 1'b0; bus_if.imem_rdata = 32'h0;
    bus_if.inst_ready = 1'b0;

    // Reset values
    #12;
    bus_if.pc_valid = 1'b1;
    #1;
    chk("rst_pc_ready", {31'd0, bus_if.pc_ready}, 32'd0);
    chk("rst_req", {31'd0, bus_if.imem_req}, 32'd0);
    chk("rst_addr", bus_if.imem_addr, 32'h0);
    chk("rst_valid", {31'd0, bus_if.inst_valid}, 32'd0);
    chk("rst_out", bus_if.inst_out, NOP_W);
    chk("rst_pc", bus_if.inst_pc, 32'h0);
    chk("rst_fault", {31'd0, bus_if.inst_fault}, 32'd0);
    bus_if.pc_valid = 1'b0;
    #4 rst_n = 1'b1;
    step();

    // Table of single fetches, popped one by one
    for (int v = 0; v < 5; v++) begin
      issue(vecs[v].pc, vecs[v].gnt_delay, vecs[v].rdata);
      chk_head("vec", vecs[v].exp_word, vecs[v].exp_pc, vecs[v].exp_fault);
      pop_one();
      chk("vec_single_entry", {31'd0, bus_if.inst_valid}, 32'd0);
    end

    // FIFO full: two fetches, no pops
    issue(32'h00000000, 0, 32'hAAAA0001);
    issue(32'h00000004, 0, 32'hBBBB0002);
    bus_if.pc_in = 32'h00000008;
    bus_if.pc_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("full_pc_ready", {31'd0, bus_if.pc_ready}, 32'd0);
      chk_head("full_stall", 32'hAAAA0001, 32'h00000000, 1'b0);
      step();
      chk("full_no_req", {31'd0, bus_if.imem_req}, 32'd0);
    end
    bus_if.pc_valid = 1'b0;
    pop_one();
    chk_head("full_second", 32'hBBBB0002, 32'h00000004, 1'b0);
    chk("after_pop_pc_ready", {31'd0, bus_if.pc_ready}, 32'd1);
    pop_one();
    chk("full_drained", {31'd0, bus_if.inst_valid}, 32'd0);

    // Flush in WAIT with one queued fault entry
    issue(32'h00000006, 0, 32'h0);
    bus_if.pc_in = 32'h00000008;
    bus_if.pc_valid = 1'b1;
    step();
    bus_if.pc_valid = 1'b0;
    bus_if.imem_gnt = 1'b1;
    step();
    bus_if.imem_gnt = 1'b0;
    bus_if.flush = 1'b1;
    #1;
    chk("flush_pc_ready", {31'd0, bus_if.pc_ready}, 32'd0);
    step();
    bus_if.flush = 1'b0;
    chk("flush_empties", {31'd0, bus_if.inst_valid}, 32'd0);
    chk("flush_still_busy", {31'd0, bus_if.pc_ready}, 32'd0);
    bus_if.imem_rvalid = 1'b1;
    bus_if.imem_rdata = 32'hDEADBEEF;
    step();
    bus_if.imem_rvalid = 1'b0;
    chk("flush_discard", {31'd0, bus_if.inst_valid}, 32'd0);
    chk("flush_idle_ready", {31'd0, bus_if.pc_ready}, 32'd1);
    step();
    chk("flush_discard_late", {31'd0, bus_if.inst_valid}, 32'd0);
    issue(32'h00000020, 0, 32'h02000293);
    chk_head("post_flush", 32'h02000293, 32'h00000020, 1'b0);
    pop_one();

    // Reset while in REQ with one entry queued
    issue(32'h00000003, 0, 32'h0);
    bus_if.pc_in = 32'h00000040;
    bus_if.pc_valid = 1'b1;
    step();
    bus_if.pc_valid = 1'b0;
    chk("prerst_req", {31'd0, bus_if.imem_req}, 32'd1);
    chk("prerst_valid", {31'd0, bus_if.inst_valid}, 32'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("midrst_req", {31'd0, bus_if.imem_req}, 32'd0);
    chk("midrst_valid", {31'd0, bus_if.inst_valid}, 32'd0);
    chk("midrst_pc_ready", {31'd0, bus_if.pc_ready}, 32'd0);
    #3 rst_n = 1'b1;
    step();
    chk("postrst_pc_ready", {31'd0, bus_if.pc_ready}, 32'd1);
    chk("postrst_addr", bus_if.imem_addr, 32'h0);
    chk("postrst_out", bus_if.inst_out, NOP_W);
    issue(32'h00000100, 0, 32'h00500093);
    chk_head("postrst_fetch", 32'h00500093, 32'h00000100, 1'b0);
    pop_one();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
